// File: rtl/dmi_tl_resp_if.sv
// Bundles the TileLink A-issue, D-channel and DMI response signals of dmi_tl_resp.
interface dmi_tl_resp_if;
  logic        a_fire;
  logic        a_source;
  logic        a_is_get;
  logic        req_allow;
  logic        busy;
  logic        d_valid;
  logic        d_ready;
  logic [2:0]  d_opcode;
  logic        d_source;
  logic        d_denied;
  logic        d_corrupt;
  logic [31:0] d_data;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic [1:0]  resp_code;

  modport master (
    output a_fire, a_source, a_is_get, d_valid, d_opcode, d_source,
           d_denied, d_corrupt, d_data, resp_ready,
    input  req_allow, busy, d_ready, resp_valid, resp_data, resp_code
  );

  modport slave (
    input  a_fire, a_source, a_is_get, d_valid, d_opcode, d_source,
           d_denied, d_corrupt, d_data, resp_ready,
    output req_allow, busy, d_ready, resp_valid, resp_data, resp_code
  );
endinterface

// File: rtl/dmi_tl_resp.sv
// Tracks one outstanding TL request and queues DMI responses from D beats.
// Optional response timeout is enabled by defining DMI_RESP_TIMEOUT_EN.
module dmi_tl_resp #(
  parameter int TIMEOUT_CYCLES = 1023,
  parameter int DEPTH          = 2
) (
  input  logic         i_clock,
  input  logic         i_reset_n,
  dmi_tl_resp_if.slave bus
);
  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_source;
  logic          r_is_get;
  logic [31:0]   r_mem_data [DEPTH];
  logic [1:0]    r_mem_code [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  logic          w_busy;
  logic          w_full;
  logic          w_empty;
  logic          w_d_fire;
  logic          w_a_take;
  logic          w_push;
  logic          w_pop;
  logic          w_timeout;
  logic          w_stale;
  logic          w_ok;
  logic [31:0]   w_push_data;
  logic [1:0]    w_push_code;

  assign w_full   = (r_count == FULL_CNT);
  assign w_empty  = (r_count == '0);
  assign w_d_fire = bus.d_valid && bus.d_ready;
  assign w_a_take = bus.a_fire && (r_state == ST_IDLE);
  assign w_pop    = !w_empty && bus.resp_ready;
  assign w_push   = (w_d_fire && w_busy) || w_timeout;

  assign bus.busy       = w_busy;
  assign bus.req_allow  = !w_busy && !w_full;
  assign bus.d_ready    = !w_full || w_stale;
  assign bus.resp_valid = !w_empty;
  assign bus.resp_data  = r_mem_data[r_rd_ptr];
  assign bus.resp_code  = r_mem_code[r_rd_ptr];

`ifdef DMI_RESP_TIMEOUT_EN
  localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT_CYCLES);
  logic [15:0] r_tmo_cnt;
  logic        r_stale;

  // Counter saturates at the limit so a timeout blocked by a full FIFO fires once space frees.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_tmo_cnt <= 16'd0;
    end else if (w_a_take || w_d_fire || w_timeout) begin
      r_tmo_cnt <= 16'd0;
    end else if (w_busy && (r_tmo_cnt != TMO_LIMIT)) begin
      r_tmo_cnt <= r_tmo_cnt + 16'd1;
    end else begin
      r_tmo_cnt <= r_tmo_cnt;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_stale <= 1'b0;
    end else if (w_a_take) begin
      r_stale <= 1'b0;
    end else if (w_timeout) begin
      r_stale <= 1'b1;
    end else if (w_d_fire) begin
      r_stale <= 1'b0;
    end else begin
      r_stale <= r_stale;
    end
  end

  assign w_timeout = w_busy && (r_tmo_cnt == TMO_LIMIT) && !w_full && !w_d_fire;
  assign w_stale   = r_stale;
`else
  logic [31:0] w_unused_timeout_cfg;
  assign w_unused_timeout_cfg = 32'(TIMEOUT_CYCLES);
  assign w_timeout = 1'b0;
  assign w_stale   = 1'b0;
`endif

  // State register
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state: a_fire while busy is ignored
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_a_take) w_state_nxt = ST_BUSY;
        else          w_state_nxt = ST_IDLE;
      end
      ST_BUSY: begin
        if (w_d_fire || w_timeout) w_state_nxt = ST_IDLE;
        else                       w_state_nxt = ST_BUSY;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_busy = 1'b0;
    case (r_state)
      ST_BUSY: w_busy = 1'b1;
      default: w_busy = 1'b0;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_source <= 1'b0;
      r_is_get <= 1'b0;
    end else if (w_a_take) begin
      r_source <= bus.a_source;
      r_is_get <= bus.a_is_get;
    end else begin
      r_source <= r_source;
      r_is_get <= r_is_get;
    end
  end

  // Response classification for the entry being enqueued
  always_comb begin
    w_ok        = (bus.d_opcode == (r_is_get ? 3'd1 : 3'd0)) &&
                  (bus.d_source == r_source) && !bus.d_denied && !bus.d_corrupt;
    w_push_data = 32'h0;
    w_push_code = 2'd2;
    if (w_timeout) begin
      w_push_code = 2'd3;
    end else if (w_ok) begin
      w_push_code = 2'd0;
      w_push_data = r_is_get ? bus.d_data : 32'h0;
    end else begin
      w_push_code = 2'd2;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_data[i] <= 32'h0;
        r_mem_code[i] <= 2'd0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem_data[r_wr_ptr] <= w_push_data;
        r_mem_code[r_wr_ptr] <= w_push_code;
        r_wr_ptr             <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule
